// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time ownership of a shared
// FIFO write port for a burst of up to BURST words, throttled by the FIFO flags.
//
// state | meaning
// IDLE  | no owner; pick the next valid requester from ptr upward, one cycle
// OWN   | grant[k] holds the FIFO write port; words move while not full
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full,
    input  logic               fifo_half,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_din,
    output logic [NREQ-1:0]    grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = PW + 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [NREQ-1:0] grant_d;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_d;
    logic [PW-1:0]   own_idx;
    logic [PW-1:0]   own_idx_d;
    logic [PW-1:0]   ptr_adv;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   cand;
    logic [SW-1:0]   cand_sum;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            sel_found;
    logic            own_valid;
    logic            xfer;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum = {1'b0, ptr} + SW'(i);
            if (cand_sum >= SW'(NREQ)) begin
                cand_sum = cand_sum - SW'(NREQ);
            end
            cand = cand_sum[PW-1:0];
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign own_valid = req_valid[own_idx];
    // Reset gates the write path so an aborted burst never writes in the reset cycle.
    assign xfer      = (state == OWN) && own_valid && !fifo_full && !rst;
    assign fifo_we   = xfer;
    assign req_ready = xfer ? grant : '0;
    assign fifo_din  = (state == OWN) ? req_data[int'(own_idx)*DW +: DW] : '0;

    assign cnt_inc = cnt + CW'(1);
    assign ptr_adv = (own_idx == PW'(NREQ - 1)) ? '0 : own_idx + PW'(1);

    always_comb begin
        state_d   = state;
        grant_d   = grant;
        ptr_d     = ptr;
        own_idx_d = own_idx;
        cnt_d     = cnt;
        case (state)
            IDLE: begin
                grant_d = '0;
                if (sel_found) begin
                    state_d          = OWN;
                    grant_d[sel_idx] = 1'b1;
                    own_idx_d        = sel_idx;
                    cnt_d            = '0;
                end
            end
            OWN: begin
                if (!own_valid) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                    // Half-full throttles every grant down to a single word.
                    if ((cnt_inc == CW'(BURST)) || fifo_half) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_adv;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            own_idx <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            ptr     <= ptr_d;
            own_idx <= own_idx_d;
            cnt     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: requester word sources, a write scoreboard and a
// per-cycle grant/write-enable expectation queue.
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full = 1'b0;
    logic               fifo_half = 1'b0;
    logic               fifo_we;
    logic [DW-1:0]      fifo_din;
    logic [NREQ-1:0]    grant;

    int total = 0;
    int bad   = 0;

    int remaining [NREQ];
    int seq       [NREQ];
    int wr_q[$];
    int cyc_grant_q[$];
    int cyc_we_q[$];
    logic prev_rst = 1'b0;

    fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_half (fifo_half),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] word(input int id, input int s);
        logic [31:0] iv;
        logic [31:0] sv;
        iv = id;
        sv = s;
        return {iv[2:0], sv[4:0]};
    endfunction

    task automatic push_wr(input int id, input int s);
        wr_q.push_back(((1 << id) << 8) | int'(word(id, s)));
    endtask

    task automatic push_cyc(input int g, input int w);
        cyc_grant_q.push_back(g);
        cyc_we_q.push_back(w);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = (remaining[i] > 0);
            req_data[i*DW +: DW]  = word(i, seq[i]);
        end
    endtask

    // One clock: sample at negedge, then update requester sources after the edge.
    task automatic cycle();
        logic [NREQ-1:0] took;
        int e;
        logic [31:0] ev;
        @(negedge clk);
        if (cyc_grant_q.size() > 0) begin
            chk("cyc_grant", 32'(grant), cyc_grant_q.pop_front());
            chk("cyc_we", 32'(fifo_we), cyc_we_q.pop_front());
        end
        if (fifo_full) chk("ready_while_full", 32'(req_ready), 0);
        if (rst) begin
            chk("rst_we", 32'(fifo_we), 0);
            chk("rst_ready", 32'(req_ready), 0);
            if (prev_rst) chk("rst_grant", 32'(grant), 0);
        end
        if (fifo_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'(fifo_we), 0);
            end else begin
                e  = wr_q.pop_front();
                ev = e;
                chk("wr_data", 32'(fifo_din), {24'd0, ev[7:0]});
                chk("wr_grant", 32'(grant), {24'd0, ev[15:8]});
                chk("wr_ready", 32'(req_ready), {24'd0, ev[15:8]});
            end
        end
        took     = req_ready;
        prev_rst = rst;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (took[i] && remaining[i] > 0) begin
                remaining[i]--;
                seq[i]++;
            end
        end
        apply_inputs();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        fifo_half = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 0;
            seq[i]       = 0;
        end
        apply_inputs();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic end_scenario(input string name);
        chk({name, "_wr_left"}, wr_q.size(), 0);
        chk({name, "_cyc_left"}, cyc_grant_q.size(), 0);
        wr_q.delete();
        cyc_grant_q.delete();
        cyc_we_q.delete();
    endtask

    initial begin
        int sx [NREQ];

        // All four requesters valid: four-word bursts in order 0,1,2,3,0 with an IDLE between.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 100;
            sx[i]        = 0;
        end
        apply_inputs();
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < BURST; j++) begin
                push_wr(b % NREQ, sx[b % NREQ]);
                sx[b % NREQ]++;
            end
        end
        for (int c = 0; c < 25; c++) begin
            push_cyc((c % 5 == 0) ? 0 : (1 << ((c / 5) % 4)), (c % 5 != 0) ? 1 : 0);
        end
        for (int c = 0; c < 25; c++) cycle();
        end_scenario("rr4");

        // Single requester with ten words: bursts of 4,4,2.
        do_reset();
        remaining[2] = 10;
        apply_inputs();
        for (int s = 0; s < 10; s++) push_wr(2, s);
        for (int c = 0; c < 15; c++) begin
            push_cyc((c == 0 || c == 5 || c == 10 || c == 14) ? 0 : 4,
                     (c inside {[1:4], [6:9], 11, 12}) ? 1 : 0);
        end
        for (int c = 0; c < 15; c++) cycle();
        end_scenario("burst_split");

        // FIFO full for three cycles mid-burst: grant and burst count are held.
        do_reset();
        remaining[1] = 6;
        apply_inputs();
        for (int s = 0; s < 6; s++) push_wr(1, s);
        begin
            int eg [12] = '{0, 2, 2, 2, 2, 2, 2, 2, 0, 2, 2, 2};
            int ew [12] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0};
            for (int c = 0; c < 12; c++) push_cyc(eg[c], ew[c]);
        end
        for (int c = 0; c < 3; c++) cycle();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        fifo_full = 1'b0;
        for (int c = 0; c < 6; c++) cycle();
        end_scenario("full_hold");

        // Half-full throttle: one word per grant, alternating 0,1,0.
        do_reset();
        fifo_half    = 1'b1;
        remaining[0] = 3;
        remaining[1] = 3;
        apply_inputs();
        push_wr(0, 0);
        push_wr(1, 0);
        push_wr(0, 1);
        begin
            int eg [6] = '{0, 1, 0, 2, 0, 1};
            int ew [6] = '{0, 1, 0, 1, 0, 1};
            for (int c = 0; c < 6; c++) push_cyc(eg[c], ew[c]);
        end
        for (int c = 0; c < 6; c++) cycle();
        end_scenario("half");

        // Owner drops valid after two words; pointer moves on to requester 1.
        do_reset();
        remaining[0] = 2;
        remaining[1] = 1;
        apply_inputs();
        push_wr(0, 0);
        push_wr(0, 1);
        push_wr(1, 0);
        push_wr(0, 2);
        begin
            int eg [9] = '{0, 1, 1, 1, 0, 2, 2, 0, 1};
            int ew [9] = '{0, 1, 1, 0, 0, 1, 0, 0, 1};
            for (int c = 0; c < 9; c++) push_cyc(eg[c], ew[c]);
        end
        for (int c = 0; c < 4; c++) cycle();
        remaining[0] = 1;
        apply_inputs();
        for (int c = 0; c < 5; c++) cycle();
        end_scenario("drop");

        // Reset mid-burst with requests held: no write in the reset cycle, restart at 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) remaining[i] = 100;
        apply_inputs();
        push_wr(0, 0);
        push_wr(0, 1);
        push_wr(0, 2);
        begin
            int eg [6] = '{0, 1, 1, 1, 0, 1};
            int ew [6] = '{0, 1, 1, 0, 0, 1};
            for (int c = 0; c < 6; c++) push_cyc(eg[c], ew[c]);
        end
        for (int c = 0; c < 3; c++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) cycle();
        end_scenario("rst_own");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
